// File: rtl/id_stage_reg.sv
// IF/ID pipeline register for the 3-stage RISC-V core.
// Takes fetched words over a ready/valid handshake. A one-entry skid buffer
// absorbs the word that the BRAM already has in flight when the stage stalls.
// The stage splits the held instruction into raw fields, detects load-use
// hazards against the instruction in EX, and is killed by a branch/jump flush.
module id_stage_reg #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [31:0]     fetch_inst,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic            stall_in,
    input  logic            flush,
    output logic            stall_out,
    output logic            load_use,
    output logic            id_issue,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_inst,
    output logic [6:0]      Opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [19:0]     immA,
    output logic [11:0]     immB,
    output logic [6:0]      immC,
    output logic [4:0]      immD
);

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;

    logic            r_id_valid;
    logic [31:0]     r_id_inst;
    logic [XLEN-1:0] r_id_pc;
    logic            r_skid_valid;
    logic [31:0]     r_skid_inst;
    logic [XLEN-1:0] r_skid_pc;
    logic            r_ex_load_valid;
    logic [4:0]      r_ex_rd;

    logic            w_accept;
    logic            w_advance;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic            w_load_use;
    logic            w_stall;
    logic            w_issue;

    // Raw instruction fields, straight slices of the held word.
    assign Opcode = r_id_inst[6:0];
    assign rd     = r_id_inst[11:7];
    assign funct3 = r_id_inst[14:12];
    assign rs1    = r_id_inst[19:15];
    assign rs2    = r_id_inst[24:20];
    assign funct7 = r_id_inst[31:25];
    assign immA   = r_id_inst[31:12];
    assign immB   = r_id_inst[31:20];
    assign immC   = r_id_inst[31:25];
    assign immD   = r_id_inst[11:7];

    assign id_valid    = r_id_valid;
    assign id_inst     = r_id_inst;
    assign id_pc       = r_id_pc;
    assign fetch_ready = !r_skid_valid;
    assign load_use    = w_load_use;
    assign stall_out   = w_stall;
    assign id_issue    = w_issue;

    // Hazard detection and handshake qualifiers.
    always_comb begin
        w_uses_rs1 = !((Opcode == OPC_LUI) || (Opcode == OPC_AUIPC) || (Opcode == OPC_JAL));
        w_uses_rs2 = (Opcode == OPC_BRANCH) || (Opcode == OPC_STORE) || (Opcode == OPC_ARI_RTYPE);
        w_load_use = r_id_valid && r_ex_load_valid && (r_ex_rd != 5'd0) &&
                     ((w_uses_rs1 && (rs1 == r_ex_rd)) || (w_uses_rs2 && (rs2 == r_ex_rd)));
        w_stall    = stall_in || w_load_use;
        w_advance  = !w_stall && !flush;
        w_issue    = r_id_valid && w_advance;
        w_accept   = fetch_valid && !r_skid_valid;
    end

    // ID register and skid buffer: flush kills both, advance refills ID
    // (skid first), a stall parks any accepted word in the skid.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_id_valid   <= 1'b0;
            r_id_inst    <= NOP_INST;
            r_id_pc      <= RESET_PC;
            r_skid_valid <= 1'b0;
            r_skid_inst  <= NOP_INST;
            r_skid_pc    <= RESET_PC;
        end else if (flush) begin
            r_id_valid   <= 1'b0;
            r_id_inst    <= NOP_INST;
            r_skid_valid <= 1'b0;
        end else if (w_advance) begin
            if (r_skid_valid) begin
                r_id_valid   <= 1'b1;
                r_id_inst    <= r_skid_inst;
                r_id_pc      <= r_skid_pc;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_id_valid <= 1'b1;
                r_id_inst  <= fetch_inst;
                r_id_pc    <= fetch_pc;
            end else begin
                r_id_valid <= 1'b0;
                r_id_inst  <= NOP_INST;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_inst  <= fetch_inst;
            r_skid_pc    <= fetch_pc;
        end
    end

    // Track whether EX holds a load and its destination; any cycle that
    // moves EX without issuing puts a bubble there.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_ex_load_valid <= 1'b0;
            r_ex_rd         <= 5'd0;
        end else if (flush) begin
            r_ex_load_valid <= 1'b0;
        end else if (stall_in) begin
            r_ex_load_valid <= r_ex_load_valid;
        end else if (w_issue) begin
            r_ex_load_valid <= (Opcode == OPC_LOAD);
            r_ex_rd         <= rd;
        end else begin
            r_ex_load_valid <= 1'b0;
        end
    end

endmodule

// File: doc/id_stage_reg.md
Name: id_stage_reg

Overview:
- IF/ID pipeline stage of the 3-stage RISC-V core.
- Accepts fetched instruction words from the fetch unit over a ready/valid handshake, with a one-entry skid buffer for BRAM read latency.
- Holds the decode-stage instruction and splits it into the raw fields (Opcode, funct3, funct7, immA..immD, rs1, rs2, rd) that drive ImmController and the control decoder.
- Detects load-use hazards against the instruction in EX, generates the core stall, and kills the stage on branch/jump flush.

Parameters:
XLEN, 32, datapath and PC width
NOP_INST, 32'h00000013, instruction held when the stage is empty (addi x0,x0,0)
RESET_PC, 0, id_pc value at reset

Ports:
Clock  input  1  core clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
fetch_inst  input  32  instruction word from IMEM BRAM output
fetch_pc  input  XLEN  PC of fetch_inst
fetch_valid  input  1  fetch_inst/fetch_pc valid this cycle
fetch_ready  output  1  stage can accept a word; equals !skid_valid
stall_in  input  1  downstream stall (memory busy); freezes ID and EX tracking
flush  input  1  taken branch/jump resolved in EX; kill ID and skid
stall_out  output  1  stall_in | load_use; fetch PC must hold
load_use  output  1  load-use hazard detected this cycle
id_issue  output  1  id_valid & !stall_out & !flush; instruction enters EX this cycle
id_valid  output  1  ID holds a live instruction
id_pc  output  XLEN  PC of ID instruction
id_inst  output  32  ID instruction (NOP_INST when empty)
Opcode  output  7  id_inst[6:0]
rd  output  5  id_inst[11:7]
funct3  output  3  id_inst[14:12]
rs1  output  5  id_inst[19:15]
rs2  output  5  id_inst[24:20]
funct7  output  7  id_inst[31:25]
immA  output  20  id_inst[31:12]
immB  output  12  id_inst[31:20]
immC  output  7  id_inst[31:25]
immD  output  5  id_inst[11:7]

Behaviour:
- Reset (sync, priority over everything): id_valid=0, id_inst=NOP_INST, id_pc=RESET_PC, skid_valid=0 (fetch_ready=1), ex_load_valid=0, ex_rd=0. All outputs are derived from these values.
- Field outputs are combinational slices of id_inst, with zero latency.
- Handshake: a word is accepted when fetch_valid & fetch_ready. Unaccepted words are the fetch unit's responsibility to re-present.
- advance = !stall_out & !flush.
- Accepted word routing:
  - On advance: the word goes into ID if skid is empty. If skid is full, skid goes into ID, which cannot coincide with an accept because fetch_ready=0.
  - When !advance and !flush: the word goes into the skid.
- Advance with nothing available: id_valid<=0 and id_inst<=NOP_INST.
- Stall (stall_out=1, flush=0): ID holds id_inst/id_pc/id_valid. Skid holds unless it is filling.
- Flush: overrides stall.
  - Next cycle: id_valid=0, id_inst=NOP_INST, skid_valid=0, ex_load_valid=0.
  - Any word accepted in the flush cycle is discarded.
- uses_rs1 = Opcode not in {LUI, AUIPC, JAL}.
- uses_rs2 = Opcode in {BRANCH, STORE, ARI_RTYPE}.
- load_use = id_valid & ex_load_valid & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- EX tracking:
  - On id_issue: ex_load_valid<=(Opcode==OPC_LOAD), ex_rd<=rd.
  - On load_use & !stall_in: ex_load_valid<=0 (bubble enters EX).
  - On stall_in: hold.
- A load_use stall lasts exactly one cycle unless stall_in extends it.
- stall_in and load_use together: both hold; load_use is still reported.

Test Plan:
- Straight-line: words 0x00500093@0x0, 0x00108113@0x4 on consecutive cycles, no stalls -> each appears on id_inst one cycle after accept; Opcode=0x13, rd=1 then 2, id_issue=1 each cycle.
- Skid: stall_in=1 for 2 cycles while 0x00C00193@0x8 is accepted -> fetch_ready=0 next cycle, ID holds previous word. After release, id_inst=0x00C00193, id_pc=0x8, fetch_ready=1 again.
- Load-use:
  - lw x5,0(x1) then add x6,x5,x2 -> load_use=1 for one cycle with add in ID, then add issues.
  - Same with rd=x0 -> no stall.
  - Same with lui x5 -> no stall.
- Flush: assert flush while ID valid, skid full, and a word is offered -> next cycle id_valid=0, id_inst=0x00000013, fetch_ready=1, and the offered word never appears.
- Reset mid-stream: Reset during skid full and load_use -> next cycle all reset values, stall_out=0, fetch_ready=1.
- Field split: id_inst=0xFE5FF0EF (jal) -> immA=0xFE5FF, immB=0xFE5, immC=0x7F, immD=0x01, rd=1, Opcode=0x6F.
